alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the integer pipeline port and the address-generation/debug port.
- Arbitrates round-robin and registers the winning operands into the ALU input ports.
- Captures ALUResult/Zero after one execute cycle and returns them to the winning requester over a valid/ready response handshake.
- Processes one operation at a time through FSM IDLE -> EXEC -> RESP.

Parameters:
DATA_WIDTH, 32, operand/result width; matches ALU.
ALU_CTRL_WIDTH, 4, ALU control code width; matches ALU.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
Req0Valid  input  1  requester 0 has an operation
Req0Ready  output  1  requester 0 operation accepted this cycle
Req0SrcA  input  DATA_WIDTH  requester 0 operand A
Req0SrcB  input  DATA_WIDTH  requester 0 operand B
Req0Ctrl  input  ALU_CTRL_WIDTH  requester 0 ALU control code
Req0PC  input  DATA_WIDTH  requester 0 PC (used by auipc/jal codes)
Req1Valid, Req1Ready, Req1SrcA, Req1SrcB, Req1Ctrl, Req1PC  same as requester 0, for requester 1
Resp0Valid  output  1  result available for requester 0
Resp0Ready  input  1  requester 0 takes result
Resp1Valid  output  1  result available for requester 1
Resp1Ready  input  1  requester 1 takes result
RespResult  output  DATA_WIDTH  shared result bus; qualified by RespNValid
RespZero  output  1  shared zero flag; qualified by RespNValid
AluSrcA  output  DATA_WIDTH  to ALU SrcA
AluSrcB  output  DATA_WIDTH  to ALU SrcB
AluCtrl  output  ALU_CTRL_WIDTH  to ALU ALUControl
AluPC  output  DATA_WIDTH  to ALU PC
AluResult  input  DATA_WIDTH  from ALU ALUResult
AluZero  input  1  from ALU Zero
Busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, LastGrant=1, Owner=0.
  - AluSrcA/AluSrcB/AluPC/RespResult = 0, AluCtrl = 0, RespZero = 0.
  - All Ready/Valid outputs and Busy are 0 while rst_n is low.
  - Reset mid-operation discards the operation; no response is produced.
- Grant (combinational, IDLE only):
  - Only one ReqNValid high: grant that requester.
  - Both high: grant requester != LastGrant. First tie after reset goes to requester 0.
  - ReqNReady = (state==IDLE) & grantN. Ready may depend on Valid. Valid never depends on Ready.
  - At most one ReqNReady high per cycle. Both Readys are 0 in EXEC and RESP.
- Accept (edge with ReqNValid & ReqNReady):
  - Register that requester's SrcA/SrcB/Ctrl/PC into AluSrcA/AluSrcB/AluCtrl/AluPC.
  - Owner=N, LastGrant=N, state->EXEC.
- Requester contract:
  - Hold Valid and payload stable until Ready.
  - The arbiter keeps no record of a pending, ungranted request.
- EXEC (exactly 1 cycle):
  - ALU ports are stable from registers.
  - At the edge, RespResult<=AluResult and RespZero<=AluZero; state->RESP.
- RESP:
  - RespOwnerValid=1; the other RespValid=0.
  - RespResult/RespZero hold until handshake.
  - On RespOwnerValid & RespOwnerReady, state->IDLE.
  - Ready already high on entry: the handshake completes in the first RESP cycle.
- ALU outputs hold their last values in IDLE and RESP; they are not cleared.
- Latency: accept at edge k -> RespValid high in cycle after edge k+1. Best-case throughput: 1 op / 3 cycles.
- A requester may present a new Valid in the same cycle its response handshakes. It is considered in the following IDLE cycle.
- AluCtrl codes are passed through unchecked; illegal codes are the ALU's concern.
- Busy = (state != IDLE).

Test Plan:
- Single op:
  - Stimulus: reset, then Req0 add SrcA=5, SrcB=7, Ctrl=0000, Resp0Ready=1.
  - Required: Req0Ready=1 in the first IDLE cycle; Resp0Valid 2 cycles later; RespResult=12, RespZero=0; back to IDLE next cycle.
- Tie and round-robin:
  - Stimulus: Req0 and Req1 both valid continuously after reset; Req0 sub 3-3, Req1 xor 0xF0^0x0F.
  - Required: grants alternate 0,1,0,1. Req0 result 0 with RespZero=1. Req1 result 0xFF.
- Backpressure:
  - Stimulus: Req1 lui SrcB=1, Ctrl=1011; Resp1Ready low for 4 cycles.
  - Required: Resp1Valid stays high; RespResult=0x1000 stable; Req0Ready=0 throughout; handshake on the cycle Ready rises.
- PC path:
  - Stimulus: Req0 Ctrl=1100, PC=0x100.
  - Required: RespResult=0x104. AluPC=0x100 during EXEC.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during EXEC.
  - Required: Busy, RespValid and Ready drop immediately; all ALU drive outputs =0; after release, a tie grants requester 0.
- Lone requester repeat:
  - Stimulus: only Req1 valid for 3 back-to-back ops.
  - Required: each is granted despite LastGrant=1; one op per 3 cycles.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of the shared ALU arbiter.
// slave is the arbiter's view; master is the surrounding requesters plus ALU.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
);
    logic                      Req0Valid;
    logic                      Req0Ready;
    logic [DATA_WIDTH-1:0]     Req0SrcA;
    logic [DATA_WIDTH-1:0]     Req0SrcB;
    logic [ALU_CTRL_WIDTH-1:0] Req0Ctrl;
    logic [DATA_WIDTH-1:0]     Req0PC;

    logic                      Req1Valid;
    logic                      Req1Ready;
    logic [DATA_WIDTH-1:0]     Req1SrcA;
    logic [DATA_WIDTH-1:0]     Req1SrcB;
    logic [ALU_CTRL_WIDTH-1:0] Req1Ctrl;
    logic [DATA_WIDTH-1:0]     Req1PC;

    logic                      Resp0Valid;
    logic                      Resp0Ready;
    logic                      Resp1Valid;
    logic                      Resp1Ready;
    logic [DATA_WIDTH-1:0]     RespResult;
    logic                      RespZero;

    logic [DATA_WIDTH-1:0]     AluSrcA;
    logic [DATA_WIDTH-1:0]     AluSrcB;
    logic [ALU_CTRL_WIDTH-1:0] AluCtrl;
    logic [DATA_WIDTH-1:0]     AluPC;
    logic [DATA_WIDTH-1:0]     AluResult;
    logic                      AluZero;

    logic                      Busy;

    modport slave (
        input  Req0Valid, Req0SrcA, Req0SrcB, Req0Ctrl, Req0PC,
        output Req0Ready,
        input  Req1Valid, Req1SrcA, Req1SrcB, Req1Ctrl, Req1PC,
        output Req1Ready,
        output Resp0Valid, Resp1Valid, RespResult, RespZero,
        input  Resp0Ready, Resp1Ready,
        output AluSrcA, AluSrcB, AluCtrl, AluPC,
        input  AluResult, AluZero,
        output Busy
    );

    modport master (
        output Req0Valid, Req0SrcA, Req0SrcB, Req0Ctrl, Req0PC,
        input  Req0Ready,
        output Req1Valid, Req1SrcA, Req1SrcB, Req1Ctrl, Req1PC,
        input  Req1Ready,
        input  Resp0Valid, Resp1Valid, RespResult, RespZero,
        output Resp0Ready, Resp1Ready,
        input  AluSrcA, AluSrcB, AluCtrl, AluPC,
        output AluResult, AluZero,
        input  Busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (return result).
module alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic last_q;
    logic owner_q;

    logic grant0;
    logic grant1;
    logic accept;
    logic resp_hs;

    logic [DATA_WIDTH-1:0]     src_a_q;
    logic [DATA_WIDTH-1:0]     src_b_q;
    logic [ALU_CTRL_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     res_q;
    logic                      zero_q;

    logic [DATA_WIDTH-1:0]     sel_a;
    logic [DATA_WIDTH-1:0]     sel_b;
    logic [ALU_CTRL_WIDTH-1:0] sel_ctrl;
    logic [DATA_WIDTH-1:0]     sel_pc;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            unique case ({bus.Req1Valid, bus.Req0Valid})
                2'b01: grant0 = 1'b1;
                2'b10: grant1 = 1'b1;
                2'b11: begin
                    grant0 = last_q;
                    grant1 = !last_q;
                end
                default: ;
            endcase
        end
    end

    assign accept  = grant0 | grant1;
    assign resp_hs = (state_q == RESP) &&
                     (owner_q ? bus.Resp1Ready : bus.Resp0Ready);

    always_comb begin
        sel_a    = bus.Req0SrcA;
        sel_b    = bus.Req0SrcB;
        sel_ctrl = bus.Req0Ctrl;
        sel_pc   = bus.Req0PC;
        if (grant1) begin
            sel_a    = bus.Req1SrcA;
            sel_b    = bus.Req1SrcB;
            sel_ctrl = bus.Req1Ctrl;
            sel_pc   = bus.Req1PC;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            src_a_q <= '0;
            src_b_q <= '0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_a_q <= sel_a;
                src_b_q <= sel_b;
                ctrl_q  <= sel_ctrl;
                pc_q    <= sel_pc;
                owner_q <= grant1;
                last_q  <= grant1;
            end
            if (state_q == EXEC) begin
                res_q  <= bus.AluResult;
                zero_q <= bus.AluZero;
            end
        end
    end

    // rst_n gating keeps handshakes quiet even with Valid held during reset.
    assign bus.Req0Ready  = rst_n & grant0;
    assign bus.Req1Ready  = rst_n & grant1;
    assign bus.Resp0Valid = rst_n & (state_q == RESP) & !owner_q;
    assign bus.Resp1Valid = rst_n & (state_q == RESP) & owner_q;
    assign bus.RespResult = res_q;
    assign bus.RespZero   = zero_q;
    assign bus.AluSrcA    = src_a_q;
    assign bus.AluSrcB    = src_b_q;
    assign bus.AluCtrl    = ctrl_q;
    assign bus.AluPC      = pc_q;
    assign bus.Busy       = rst_n & (state_q != IDLE);

endmodule
